// File: rtl/hqm_aw_cfg_tgt_responder_if.sv
// hqm_aw_cfg_tgt_responder_if: config types plus the core-side request/response bundle (master issues requests, slave responds)
package hqm_aw_cfg_pkg;
  typedef logic [15:0] cfg_offset_t;
  typedef struct packed {
    logic [15:0] target;
    cfg_offset_t offset;
  } cfg_addr_t;
  typedef struct packed {
    cfg_addr_t addr;
    logic [31:0] wdata;
  } cfg_req_t;
  typedef struct packed {
    logic err;
    logic [31:0] rdata;
  } cfg_rsp_t;
endpackage

interface hqm_aw_cfg_tgt_responder_if;
  import hqm_aw_cfg_pkg::*;
  logic core_cfg_req_write;
  logic core_cfg_req_read;
  cfg_req_t core_cfg_req;
  logic core_cfg_rsp_ack;
  cfg_rsp_t core_cfg_rsp;
  modport master(output core_cfg_req_write, core_cfg_req_read, core_cfg_req, input core_cfg_rsp_ack, core_cfg_rsp);
  modport slave(input core_cfg_req_write, core_cfg_req_read, core_cfg_req, output core_cfg_rsp_ack, core_cfg_rsp);
endinterface

// File: rtl/hqm_aw_cfg_tgt_responder.sv
// hqm_aw_cfg_tgt_responder: decodes core config requests to NUM_TGT targets, runs req/ack with timeout, returns one response per request (clk/rst/rst_prep, core slave bundle, tgt_* handshake, status pulses)
module hqm_aw_cfg_tgt_responder
  import hqm_aw_cfg_pkg::*;
#(
  parameter int NUM_TGT = 8,
  parameter logic [NUM_TGT*16-1:0] TGT_MAP = {16'h0017, 16'h0016, 16'h0015, 16'h0014, 16'h0013, 16'h0012, 16'h0011, 16'h0010},
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_prep,
  hqm_aw_cfg_tgt_responder_if.slave core,
  output logic [NUM_TGT-1:0] tgt_req_v,
  output logic tgt_req_write,
  output cfg_offset_t tgt_offset,
  output logic [31:0] tgt_wdata,
  input  logic [NUM_TGT-1:0] tgt_ack,
  input  logic [NUM_TGT-1:0][31:0] tgt_rdata,
  input  logic [NUM_TGT-1:0] tgt_err,
  output logic cfg_idle,
  output logic err_timeout,
  output logic err_overrun
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = NUM_TGT > 1 ? $clog2(NUM_TGT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;
  state_t state, state_nx;
  logic [SW-1:0] sel, sel_nx, hit_idx;
  logic wr, wr_nx, to, to_nx, ovr, hit, req, both, ack;
  cfg_offset_t off, off_nx;
  logic [31:0] wd, wd_nx;
  logic [CW-1:0] cnt, cnt_nx;
  cfg_rsp_t rsp, rsp_nx, cap;
  assign req = core.core_cfg_req_write | core.core_cfg_req_read;
  assign both = core.core_cfg_req_write & core.core_cfg_req_read;
  assign ack = tgt_ack[sel];
  assign cap = '{err: tgt_err[sel], rdata: wr ? 32'h0 : tgt_rdata[sel]};
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_TGT; i++)
      if (core.core_cfg_req.addr.target == TGT_MAP[i*16 +: 16]) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
  end
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    wr_nx = wr;
    off_nx = off;
    wd_nx = wd;
    cnt_nx = cnt;
    rsp_nx = rsp;
    to_nx = 1'b0;
    case (state)
      IDLE: if (req) begin
        wr_nx = core.core_cfg_req_write;
        off_nx = core.core_cfg_req.addr.offset;
        wd_nx = core.core_cfg_req.wdata;
        sel_nx = hit_idx;
        rsp_nx = '{err: 1'b1, rdata: 32'h0};
        state_nx = (hit && !both) ? ISSUE : RSP;
      end
      ISSUE: begin
        cnt_nx = '0;
        rsp_nx = ack ? cap : rsp;
        state_nx = ack ? RSP : WAIT;
      end
      WAIT: if (ack) begin
        rsp_nx = cap;
        state_nx = RSP;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        rsp_nx = '{err: 1'b1, rdata: 32'h0};
        to_nx = 1'b1;
        state_nx = RSP;
      end else cnt_nx = cnt + 1'b1;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      wr <= 1'b0;
      off <= '0;
      wd <= '0;
      cnt <= '0;
      rsp <= '0;
      to <= 1'b0;
      ovr <= 1'b0;
    end else if (rst_prep) begin
      state <= IDLE;
      to <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      wr <= wr_nx;
      off <= off_nx;
      wd <= wd_nx;
      cnt <= cnt_nx;
      rsp <= rsp_nx;
      to <= to_nx;
      ovr <= req && (state != IDLE);
    end
  end
  assign core.core_cfg_rsp_ack = !rst_prep && state == RSP;
  assign core.core_cfg_rsp = (rst_prep || state != RSP) ? '0 : rsp;
  assign tgt_req_v = (rst_prep || state != ISSUE) ? '0 : NUM_TGT'(1) << sel;
  assign tgt_req_write = !rst_prep && wr;
  assign tgt_offset = rst_prep ? '0 : off;
  assign tgt_wdata = rst_prep ? '0 : wd;
  assign cfg_idle = !rst_prep && state == IDLE;
  assign err_timeout = !rst_prep && to;
  assign err_overrun = !rst_prep && ovr;
endmodule

// File: tb/tb_hqm_aw_cfg_tgt_responder.sv
// tb_hqm_aw_cfg_tgt_responder: directed and random transactions checked against a cycle-level response model
module tb_hqm_aw_cfg_tgt_responder;
  import hqm_aw_cfg_pkg::*;
  localparam int NT = 8;
  localparam int TO = 4;
  localparam int N = TO + 5;
  localparam logic [15:0] MAP [NT] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0021, 16'h8000, 16'h00ff, 16'h0100};
  logic clk = 1'b0, rst = 1'b1, rst_prep = 1'b0;
  logic [NT-1:0] tgt_req_v, tgt_ack, tgt_err;
  logic [NT-1:0][31:0] tgt_rdata;
  logic tgt_req_write, cfg_idle, err_timeout, err_overrun;
  cfg_offset_t tgt_offset;
  logic [31:0] tgt_wdata;
  int errors = 0, checks = 0;
  hqm_aw_cfg_tgt_responder_if cif();
  hqm_aw_cfg_tgt_responder #(
    .NUM_TGT(NT),
    .TGT_MAP({16'h0100, 16'h00ff, 16'h8000, 16'h0021, 16'h0013, 16'h0012, 16'h0011, 16'h0010}),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .rst_prep(rst_prep), .core(cif),
    .tgt_req_v(tgt_req_v), .tgt_req_write(tgt_req_write), .tgt_offset(tgt_offset), .tgt_wdata(tgt_wdata),
    .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata), .tgt_err(tgt_err),
    .cfg_idle(cfg_idle), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );
  always #5 clk = ~clk;
  function automatic int lookup(input logic [15:0] t);
    for (int i = 0; i < NT; i++) if (MAP[i] == t) return i;
    return -1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic chk_quiet(input string tag, input logic idle);
    chk({tag, ".ack"}, cif.core_cfg_rsp_ack, 0);
    chk({tag, ".rsp"}, cif.core_cfg_rsp, 0);
    chk({tag, ".req_v"}, tgt_req_v, 0);
    chk({tag, ".req_write"}, tgt_req_write, 0);
    chk({tag, ".offset"}, tgt_offset, 0);
    chk({tag, ".wdata"}, tgt_wdata, 0);
    chk({tag, ".err_timeout"}, err_timeout, 0);
    chk({tag, ".err_overrun"}, err_overrun, 0);
    chk({tag, ".cfg_idle"}, cfg_idle, idle);
  endtask
  task automatic drive_req(input logic w, input logic r, input logic [15:0] tg, input logic [15:0] off, input logic [31:0] wd);
    cif.core_cfg_req_write = w;
    cif.core_cfg_req_read = r;
    cif.core_cfg_req.addr.target = tg;
    cif.core_cfg_req.addr.offset = off;
    cif.core_cfg_req.wdata = wd;
  endtask
  task automatic txn(input logic w, input logic r, input logic [15:0] tg, input int ak, input logic [31:0] rd,
                     input logic te, input logic [15:0] off, input logic [31:0] wd, input int oc);
    int idx, ec, n_ack, ack_c;
    logic hit, e_err, e_to;
    logic [31:0] e_rd;
    logic [NT-1:0] m;
    logic [32:0] got;
    idx = lookup(tg);
    hit = !(w && r) && idx >= 0;
    m = hit ? NT'(1) << idx : '0;
    e_to = 1'b0;
    if (!hit) begin
      ec = 1; e_err = 1'b1; e_rd = 0;
    end else if (ak >= 1 && ak <= TO + 1) begin
      ec = ak + 1; e_err = te; e_rd = w ? 32'h0 : rd;
    end else begin
      ec = TO + 2; e_err = 1'b1; e_rd = 0; e_to = 1'b1;
    end
    if (oc > ec) oc = 0;
    n_ack = 0; ack_c = -1; got = '0;
    for (int c = 0; c <= N; c++) begin
      tick();
      if (c == 0) drive_req(w, r, tg, off, wd);
      else if (oc != 0 && c == oc) drive_req(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), $urandom);
      else drive_req(1'b0, 1'b0, 16'($urandom), 16'($urandom), $urandom);
      tgt_ack = NT'($urandom) & ~m;
      tgt_err = NT'($urandom);
      for (int i = 0; i < NT; i++) tgt_rdata[i] = $urandom;
      if (hit && c == ak) begin
        tgt_ack[idx] = 1'b1; tgt_rdata[idx] = rd; tgt_err[idx] = te;
      end
      #1;
      if (cif.core_cfg_rsp_ack) begin
        n_ack++; ack_c = c; got = cif.core_cfg_rsp;
      end
      chk("tgt_req_v", tgt_req_v, (hit && c == 1) ? m : '0);
      chk("cfg_idle", cfg_idle, c == 0 || c > ec);
      chk("err_timeout", err_timeout, e_to && c == ec);
      chk("err_overrun", err_overrun, oc != 0 && c == oc + 1);
      if (hit && c == 1) begin
        chk("tgt_offset", tgt_offset, off);
        chk("tgt_wdata", tgt_wdata, wd);
        chk("tgt_req_write", tgt_req_write, w);
      end
    end
    chk("ack_count", n_ack, 1);
    chk("ack_cycle", ack_c, ec);
    chk("rsp", got, {e_err, e_rd});
  endtask
  initial begin
    int op;
    logic w, r;
    tgt_ack = '0; tgt_err = '0; tgt_rdata = '0;
    drive_req(1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
    repeat (3) tick();
    #1;
    chk_quiet("reset", 1'b1);
    rst = 1'b0;
    txn(1'b0, 1'b1, 16'h0012, 4, 32'h12345678, 1'b0, 16'h0040, 32'h0, 0);
    txn(1'b1, 1'b0, 16'h0007, 1, 32'h0, 1'b0, 16'h0004, 32'hcafef00d, 0);
    txn(1'b0, 1'b1, 16'h0010, 8, 32'h55aa55aa, 1'b0, 16'h0008, 32'h0, 0);
    txn(1'b1, 1'b1, 16'h0012, 2, 32'h11111111, 1'b0, 16'h000c, 32'h1, 0);
    txn(1'b0, 1'b1, 16'h0011, 3, 32'hfeedface, 1'b1, 16'h0010, 32'h0, 1);
    txn(1'b1, 1'b0, 16'h0100, 1, 32'h99999999, 1'b0, 16'hffff, 32'h87654321, 0);
    txn(1'b0, 1'b1, 16'h00ff, 5, 32'habcdef01, 1'b0, 16'h0001, 32'h0, 0);
    tick(); drive_req(1'b0, 1'b1, 16'h0013, 16'h0055, 32'h0); tgt_ack = '0;
    tick(); drive_req(1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
    tick();
    tick(); rst_prep = 1'b1; #1;
    chk_quiet("rst_prep", 1'b0);
    tick(); rst_prep = 1'b0; tgt_ack = 8'b0000_1000; #1;
    chk("prep_idle", cfg_idle, 1);
    chk("prep_noack", cif.core_cfg_rsp_ack, 0);
    txn(1'b0, 1'b1, 16'h0012, 2, 32'h0badc0de, 1'b0, 16'h0022, 32'h0, 0);
    tick(); drive_req(1'b1, 1'b0, 16'h8000, 16'h0abc, 32'hdeadbeef); tgt_ack = '0;
    tick(); drive_req(1'b0, 1'b0, 16'h0, 16'h0, 32'h0); #1;
    chk("rst_req_v", tgt_req_v, 8'b0010_0000);
    tick();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; tgt_ack = 8'b0010_0000; #1;
    chk_quiet("rst_mid", 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); tgt_ack = '0; #1;
      chk("rst_noack", cif.core_cfg_rsp_ack, 0);
      chk("rst_idle", cfg_idle, 1);
    end
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      w = (op == 0) || (op % 2 == 1);
      r = (op == 0) || (op % 2 == 0);
      txn(w, r, ($urandom_range(0, 3) == 0) ? 16'($urandom) : MAP[$urandom_range(0, NT - 1)],
          $urandom_range(0, N), $urandom, 1'($urandom_range(0, 1)), 16'($urandom), $urandom,
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 2) : 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hqm_aw_cfg_tgt_responder.md
# hqm_AW_cfg_tgt_responder

Core-side responder for the unit config ring. It receives single-beat config requests from the ring element's core port, which issues at most one outstanding request. It decodes the target field to one of NUM_TGT local register targets and runs a per-target req/ack handshake with a timeout. It returns exactly one `core_cfg_rsp_ack` pulse with `cfg_rsp_t` per accepted request: read data, or an error for decode miss, illegal opcode or timeout.

## Interface
Parameters:
- NUM_TGT, 8, number of local targets (1..16).
- TGT_MAP, NUM_TGT x 16b vector, target-field value for each target index; entries must be unique.
- TIMEOUT, 255, max cycles in WAIT before error response (>=1); counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, the single clock of the block.
- rst  in  1  reset, synchronous and active-high.
- rst_prep  in  1  abort; combinationally zeroes all request/response outputs; FSM returns to IDLE on the next edge.
- core_cfg_req_write  in  1  write request strobe, 1-cycle pulse.
- core_cfg_req_read  in  1  read request strobe, 1-cycle pulse.
- core_cfg_req  in  cfg_req_t  request; uses addr.target (16b), addr.offset, wdata (32b).
- core_cfg_rsp_ack  out  1  response strobe, 1-cycle pulse.
- core_cfg_rsp  out  cfg_rsp_t  rdata (32b) and err; all other fields 0.
- tgt_req_v  out  NUM_TGT  one-hot target request, 1-cycle pulse.
- tgt_req_write  out  1  1 = write, 0 = read; valid with tgt_req_v.
- tgt_offset  out  addr.offset width  latched offset.
- tgt_wdata  out  32  latched write data.
- tgt_ack  in  NUM_TGT  target completion pulse.
- tgt_rdata  in  NUM_TGT x 32  target read data; valid with tgt_ack.
- tgt_err  in  NUM_TGT  target error; valid with tgt_ack.
- cfg_idle  out  1  1 when FSM is IDLE and no response is pending.
- err_timeout  out  1  1-cycle pulse when a timeout response is generated.
- err_overrun  out  1  1-cycle pulse when a request arrives outside IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RSP. All outputs are registered except the rst_prep gating.
- IDLE, valid request (write xor read):
  - Latch opcode, offset and wdata; compare addr.target with every TGT_MAP entry.
  - Hit at index i: store sel=i, go to ISSUE.
  - Miss: go to RSP with err=1, rdata=0.
- IDLE, write and read both high: go to RSP with err=1, rdata=0; no target access.
- ISSUE:
  - tgt_req_v[sel]=1 for this cycle only; clear the timeout counter.
  - If tgt_ack[sel]=1 in this same cycle, capture and go to RSP; otherwise go to WAIT.
- WAIT:
  - tgt_ack[sel]=1: capture and go to RSP.
  - Otherwise, if cnt==TIMEOUT-1: go to RSP with err=1, rdata=0, and pulse err_timeout in the RSP cycle.
  - Otherwise: cnt++.
- Capture: rdata=tgt_rdata[sel] for reads and 0 for writes; err=tgt_err[sel].
- RSP: core_cfg_rsp_ack=1 with the captured response for one cycle, then go to IDLE.
- Acks ignored:
  - tgt_ack on a non-selected index, at any time.
  - Any tgt_ack while in IDLE, including late acks from a timed-out target.
- Request while not IDLE: dropped, err_overrun pulses the next cycle, the current transaction is unaffected.
- rst_prep: outputs are forced to 0 in the same cycle. The FSM goes to IDLE on the next edge and any in-flight response is discarded (no ack is ever produced for it).
- rst: on the next edge the FSM enters IDLE and the counter and latches clear.
  - Reset values: core_cfg_rsp_ack=0, core_cfg_rsp=0, tgt_req_v=0, tgt_req_write=0, tgt_offset=0, tgt_wdata=0, err_timeout=0, err_overrun=0, cfg_idle=1.

## Timing
- Cycle 0 is the cycle in which the request strobe is high.
- Miss or illegal opcode: core_cfg_rsp_ack in cycle 1.
- Hit:
  - tgt_req_v in cycle 1.
  - A target ack in cycle k (k>=1) gives core_cfg_rsp_ack in cycle k+1; the minimum is cycle 2 (ack in the ISSUE cycle).
- Timeout: WAIT occupies cycles 2..TIMEOUT+1; core_cfg_rsp_ack and err_timeout in cycle TIMEOUT+2.
- Earliest next accepted request: the cycle after RSP.
- cfg_idle deasserts in cycle 1 and reasserts the cycle after RSP.

## Test plan
- Read, TGT_MAP[2]=0x0012, target=0x0012; target 2 acks in cycle 4 with rdata=0x12345678, err=0 -> tgt_req_v=0b100 in cycle 1 only; core_cfg_rsp_ack in cycle 5 with rdata=0x12345678, err=0; cfg_idle high from cycle 6.
- Write target=0x0007, not in map -> no tgt_req_v; ack in cycle 1 with err=1, rdata=0.
- TIMEOUT=4, read hits target 0, no ack -> ack and err_timeout in cycle 6 with err=1; a tgt_ack[0] in cycle 8 produces no further ack.
- Write and read high together -> err=1 ack in cycle 1. A second request in cycle 1 of a hit transaction -> err_overrun in cycle 2; exactly one ack is produced.
- rst_prep high in cycle 3 of a WAIT -> all outputs 0 in cycle 3, FSM IDLE in cycle 4, no ack ever; a new read in cycle 5 completes normally.
- rst asserted mid-WAIT for 1 cycle -> all outputs at reset values the next cycle, cfg_idle=1; a later target ack is ignored.
